// File: rtl/sum_hls_axis_stall_detector_if.sv
// ---------------------------------------------------------------------------
// sum_hls_axis_stall_detector_if
// Bundle of the tvalid/tready taps of every kernel-facing AXI-Stream channel
// monitored by the stall detector.
//   ch_tvalid [NUM_CHANNELS]  tvalid of each monitored channel
//   ch_tready [NUM_CHANNELS]  tready of each monitored channel
// Modports:
//   master  side that drives the taps (the stream fabric / test stimulus)
//   slave   observer side (the stall detector); inputs only
// ---------------------------------------------------------------------------
interface sum_hls_axis_stall_detector_if #(
    parameter int NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS-1:0] ch_tvalid;
    logic [NUM_CHANNELS-1:0] ch_tready;

    modport master (output ch_tvalid, output ch_tready);
    modport slave  (input  ch_tvalid, input  ch_tready);
endinterface

// File: rtl/sum_hls_axis_stall_detector.sv
// ---------------------------------------------------------------------------
// sum_hls_axis_stall_detector
// Per-channel AXI-Stream stall detector for one HLS kernel instance. A
// channel is flagged blocked after STALL_THRESHOLD consecutive waiting
// cycles; the first channel to block is latched for debug readout.
// Purely observational: never drives tvalid/tready.
// Ports:
//   clock              system clock
//   reset              synchronous active-high reset
//   enable             detection enable; 0 clears counters and flags
//   inst_idle          kernel idle; 1 clears counters and flags
//   axis               tvalid/tready taps (slave modport)
//   clear_sticky       clears first_block_valid / first_block_idx
//   axis_block_sigs    registered per-channel block flags
//   any_block          registered OR of the block flags
//   first_block_valid  sticky: some channel blocked since last clear
//   first_block_idx    index of the first blocked channel
// ---------------------------------------------------------------------------
module sum_hls_axis_stall_detector #(
    parameter int                      NUM_CHANNELS    = 2,
    parameter int                      STALL_THRESHOLD = 16,
    parameter logic [NUM_CHANNELS-1:0] OUTPUT_MASK     = 2'b10,
    parameter int                      IDX_WIDTH       =
        (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          inst_idle,
    sum_hls_axis_stall_detector_if.slave  axis,
    input  logic                          clear_sticky,
    output logic [NUM_CHANNELS-1:0]       axis_block_sigs,
    output logic                          any_block,
    output logic                          first_block_valid,
    output logic [IDX_WIDTH-1:0]          first_block_idx
);

    localparam int CNT_W = $clog2(STALL_THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_THRESHOLD);
    // Counter value at which the next qualified cycle is the threshold-th one.
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STALL_THRESHOLD - 1);

    logic [CNT_W-1:0]        cnt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wait_v;
    logic [NUM_CHANNELS-1:0] qual;
    logic [NUM_CHANNELS-1:0] block_nxt;
    logic [IDX_WIDTH-1:0]    lowest_idx;

    always_comb begin
        wait_v    = '0;
        qual      = '0;
        block_nxt = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            // Inputs wait when the kernel is ready but starved; outputs wait
            // when the kernel offers data that is not accepted.
            if (OUTPUT_MASK[i])
                wait_v[i] = axis.ch_tvalid[i] & ~axis.ch_tready[i];
            else
                wait_v[i] = axis.ch_tready[i] & ~axis.ch_tvalid[i];
            qual[i]      = wait_v[i] & enable & ~inst_idle;
            block_nxt[i] = qual[i] && (cnt[i] >= CNT_HIT);
        end
    end

    // Lowest currently-blocked channel; scanning downward lets the lowest win.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i])
                lowest_idx = IDX_WIDTH'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                cnt[i] <= '0;
            axis_block_sigs   <= '0;
            any_block         <= 1'b0;
            first_block_valid <= 1'b0;
            first_block_idx   <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (!qual[i])
                    cnt[i] <= '0;
                else if (cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
            axis_block_sigs <= block_nxt;
            any_block       <= |block_nxt;
            // Clear wins over capture; a still-asserted block recaptures on
            // the following edge.
            if (clear_sticky) begin
                first_block_valid <= 1'b0;
                first_block_idx   <= '0;
            end else if (!first_block_valid && (|axis_block_sigs)) begin
                first_block_valid <= 1'b1;
                first_block_idx   <= lowest_idx;
            end
        end
    end

endmodule

// File: tb/tb_sum_hls_axis_stall_detector.sv
module tb_sum_hls_axis_stall_detector;

    localparam int NCH = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       inst_idle = 1'b0;
    logic       clear_sticky = 1'b0;
    logic [1:0] axis_block_sigs;
    logic       any_block;
    logic       first_block_valid;
    logic [0:0] first_block_idx;

    int total_cnt = 0;
    int pass_cnt  = 0;

    sum_hls_axis_stall_detector_if #(.NUM_CHANNELS(NCH)) axis_bus ();

    sum_hls_axis_stall_detector #(
        .NUM_CHANNELS    (NCH),
        .STALL_THRESHOLD (4),
        .OUTPUT_MASK     (2'b10)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .inst_idle         (inst_idle),
        .axis              (axis_bus),
        .clear_sticky      (clear_sticky),
        .axis_block_sigs   (axis_block_sigs),
        .any_block         (any_block),
        .first_block_valid (first_block_valid),
        .first_block_idx   (first_block_idx)
    );

    always #5 clock = ~clock;

    // Observation vector: {block[1:0], any_block, first_block_valid, idx}
    logic [4:0] obs;
    assign obs = {axis_block_sigs, any_block, first_block_valid, first_block_idx};

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic quiet();
        axis_bus.ch_tvalid = 2'b00;
        axis_bus.ch_tready = 2'b00;
        enable       = 1'b1;
        inst_idle    = 1'b0;
        clear_sticky = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        step(2);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL reset_state: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        reset = 1'b0;
        step(2);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL idle_quiet: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
    endtask

    task automatic test_input_starvation();
        do_reset();
        axis_bus.ch_tready[0] = 1'b1;
        step(3);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL starve_pre: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b01100)
            $display("FAIL starve_assert: got %b expected %b", obs, 5'b01100);
        else pass_cnt++;
        step(2);
        total_cnt++;
        if (obs !== 5'b01110)
            $display("FAIL starve_sticky: got %b expected %b", obs, 5'b01110);
        else pass_cnt++;
        axis_bus.ch_tvalid[0] = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 5'b00010)
            $display("FAIL starve_release: got %b expected %b", obs, 5'b00010);
        else pass_cnt++;
    endtask

    task automatic test_output_glitch();
        do_reset();
        axis_bus.ch_tvalid[1] = 1'b1;
        step(3);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL glitch_run1: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        axis_bus.ch_tready[1] = 1'b1;
        step(1);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL glitch_xfer: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        axis_bus.ch_tready[1] = 1'b0;
        step(3);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL glitch_run2_pre: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b10100)
            $display("FAIL glitch_run2_assert: got %b expected %b", obs, 5'b10100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b10111)
            $display("FAIL glitch_sticky_idx1: got %b expected %b", obs, 5'b10111);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        axis_bus.ch_tready = 2'b01;
        axis_bus.ch_tvalid = 2'b10;
        step(4);
        total_cnt++;
        if (obs !== 5'b11100)
            $display("FAIL simul_assert: got %b expected %b", obs, 5'b11100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b11110)
            $display("FAIL simul_lowest_idx: got %b expected %b", obs, 5'b11110);
        else pass_cnt++;
        clear_sticky = 1'b1;
        step(1);
        clear_sticky = 1'b0;
        total_cnt++;
        if (obs !== 5'b11100)
            $display("FAIL simul_clear: got %b expected %b", obs, 5'b11100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b11110)
            $display("FAIL simul_recapture: got %b expected %b", obs, 5'b11110);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            axis_bus.ch_tready[0] = 1'b1;
            step(3);
            if (pass == 0) inst_idle = 1'b1;
            else           enable    = 1'b0;
            step(1);
            inst_idle = 1'b0;
            enable    = 1'b1;
            total_cnt++;
            if (obs !== 5'b00000)
                $display("FAIL gate%0d_during: got %b expected %b", pass, obs, 5'b00000);
            else pass_cnt++;
            step(3);
            total_cnt++;
            if (obs !== 5'b00000)
                $display("FAIL gate%0d_restart_pre: got %b expected %b", pass, obs, 5'b00000);
            else pass_cnt++;
            step(1);
            total_cnt++;
            if (obs !== 5'b01100)
                $display("FAIL gate%0d_restart_assert: got %b expected %b", pass, obs, 5'b01100);
            else pass_cnt++;
            step(1);
            if (pass == 0) inst_idle = 1'b1;
            else           enable    = 1'b0;
            step(1);
            inst_idle = 1'b0;
            enable    = 1'b1;
            total_cnt++;
            if (obs !== 5'b00010)
                $display("FAIL gate%0d_sticky_kept: got %b expected %b", pass, obs, 5'b00010);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int bad = 0;
        do_reset();
        axis_bus.ch_tvalid[1] = 1'b1;
        step(4);
        for (int k = 0; k < 300; k++) begin
            step(1);
            if (axis_block_sigs !== 2'b10 || any_block !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL saturation_hold: %0d bad cycles, expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (obs !== 5'b10111)
            $display("FAIL saturation_end: got %b expected %b", obs, 5'b10111);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        // Continues from the saturation stall: block[1]=1 and sticky idx=1.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL rst_mid_clear: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if (obs !== 5'b00000)
            $display("FAIL rst_mid_pre: got %b expected %b", obs, 5'b00000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b10100)
            $display("FAIL rst_mid_reassert: got %b expected %b", obs, 5'b10100);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (obs !== 5'b10111)
            $display("FAIL rst_mid_recapture: got %b expected %b", obs, 5'b10111);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_input_starvation();
        test_output_glitch();
        test_simultaneous();
        test_gating();
        test_saturation();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
